tlb_sfence_assoc: RTL and testbench

- Parametrised fully-associative TLB; successor to the fixed Sv39 TLB.
- Depth, VPN/PPN/ASID widths and page-level count are configurable.
- Adds global-page support, round-robin replacement, and selective SFENCE.VMA-style invalidation (by ASID, by VPN, or both).
- Sits between the translation requester (fetch/LSU) and the PTW. Lookup is combinational; misses are walked by a single-outstanding-miss FSM.

---
 rtl/tlb_sfence_assoc.sv | 248 ++++++++++++++++++++++++
 tb/tb_tlb_sfence_assoc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_sfence_assoc.sv
// rtl/tlb_sfence_assoc.sv - fully-associative TLB with selective SFENCE-style flush and single-miss walker
module tlb_sfence_assoc #(
  parameter int ENTRIES  = 16,
  parameter int LEVELS   = 3,
  parameter int LVL_BITS = 9,
  parameter int VPN_W    = LEVELS * LVL_BITS,
  parameter int PPN_W    = 44,
  parameter int ASID_W   = 16,
  parameter int LVL_W    = $clog2(LEVELS)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              vm_enable_i,
  input  logic              req_valid_i,
  input  logic [VPN_W-1:0]  req_vpn_i,
  input  logic [ASID_W-1:0] req_asid_i,
  input  logic              req_store_i,
  input  logic              req_fetch_i,
  input  logic              req_priv_s_i,
  input  logic              sum_i,
  input  logic              mxr_i,
  output logic              ready_o,
  output logic              resp_miss_o,
  output logic [PPN_W-1:0]  resp_ppn_o,
  output logic              resp_xcpt_ld_o,
  output logic              resp_xcpt_st_o,
  output logic              resp_xcpt_if_o,
  output logic              ptw_req_valid_o,
  input  logic              ptw_req_ready_i,
  output logic [VPN_W-1:0]  ptw_req_vpn_o,
  output logic [ASID_W-1:0] ptw_req_asid_o,
  output logic              ptw_req_store_o,
  output logic              ptw_req_fetch_o,
  input  logic              ptw_resp_valid_i,
  input  logic [PPN_W-1:0]  ptw_resp_ppn_i,
  input  logic [LVL_W-1:0]  ptw_resp_level_i,
  input  logic [6:0]        ptw_resp_perm_i,
  input  logic              ptw_resp_error_i,
  input  logic              flush_valid_i,
  input  logic              flush_asid_en_i,
  input  logic [ASID_W-1:0] flush_asid_i,
  input  logic              flush_vpn_en_i,
  input  logic [VPN_W-1:0]  flush_vpn_i,
  output logic              pmu_access_o,
  output logic              pmu_miss_o
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DISCARD} state_e;
  state_e state_q, state_d;

  // Entry storage; perm_q packs {ur,uw,ux,sr,sw,sx}
  logic [VPN_W-1:0]   vpn_q   [ENTRIES];
  logic [ASID_W-1:0]  asid_q  [ENTRIES];
  logic [PPN_W-1:0]   ppn_q   [ENTRIES];
  logic [LVL_W-1:0]   level_q [ENTRIES];
  logic [5:0]         perm_q  [ENTRIES];
  logic [ENTRIES-1:0] g_q, d_q, fault_q, nempty_q, nempty_d, flush_sel;

  // Outstanding walk
  logic [VPN_W-1:0]  wlk_vpn_q;
  logic [ASID_W-1:0] wlk_asid_q;
  logic              wlk_store_q, wlk_fetch_q;
  logic [IDX_W-1:0]  fill_idx_q, ptr_q, victim, hit_idx;

  logic hit, have_empty, lookup, is_ld, read_ok, write_ok, exec_ok;
  logic hit_fault, hit_d, dirty_upg, miss, accept, accept_miss, fill_en, clr_en;
  logic [5:0]       hp;
  logic [PPN_W-1:0] lo_mask;

  // Bits at or above the leaf level's page offset take part in a VPN compare
  function automatic logic [VPN_W-1:0] vpn_hi_mask(input logic [LVL_W-1:0] lvl);
    logic [VPN_W-1:0] m;
    for (int b = 0; b < VPN_W; b++) m[b] = (b >= int'(lvl) * LVL_BITS);
    return m;
  endfunction

  // Bits below the leaf level's page offset are passed through from the VPN
  function automatic logic [PPN_W-1:0] ppn_lo_mask(input logic [LVL_W-1:0] lvl);
    logic [PPN_W-1:0] m;
    for (int b = 0; b < PPN_W; b++) m[b] = (b < int'(lvl) * LVL_BITS);
    return m;
  endfunction

  // Associative match, lowest index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (nempty_q[i] && (g_q[i] || asid_q[i] == req_asid_i) &&
          (((vpn_q[i] ^ req_vpn_i) & vpn_hi_mask(level_q[i])) == '0)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hp        = perm_q[hit_idx];
  assign hit_fault = fault_q[hit_idx];
  assign hit_d     = d_q[hit_idx];
  assign lo_mask   = ppn_lo_mask(level_q[hit_idx]);
  assign read_ok   = (req_priv_s_i ? (hp[2] | (sum_i & hp[5])) : hp[5]) |
                     (mxr_i & (req_priv_s_i ? hp[0] : hp[3]));
  assign write_ok  = req_priv_s_i ? (hp[1] | (sum_i & hp[4])) : hp[4];
  assign exec_ok   = req_priv_s_i ? hp[0] : hp[3];
  assign lookup    = req_valid_i & vm_enable_i;
  assign is_ld     = ~req_store_i & ~req_fetch_i;
  assign dirty_upg = req_store_i & hit & ~hit_fault & write_ok & ~hit_d;
  assign miss      = lookup & (~hit | dirty_upg);

  assign resp_miss_o    = miss;
  assign resp_ppn_o     = !vm_enable_i ? PPN_W'(req_vpn_i) :
                          (hit ? ((ppn_q[hit_idx] & ~lo_mask) | (PPN_W'(req_vpn_i) & lo_mask)) : '0);
  assign resp_xcpt_ld_o = lookup & hit & is_ld       & (hit_fault | ~read_ok);
  assign resp_xcpt_st_o = lookup & hit & req_store_i & (hit_fault | ~write_ok);
  assign resp_xcpt_if_o = lookup & hit & req_fetch_i & (hit_fault | ~exec_ok);

  assign accept      = (state_q == IDLE) & lookup;
  assign accept_miss = accept & miss;
  assign clr_en      = accept & hit & (hit_fault | dirty_upg);
  assign fill_en     = (state_q == WAIT) & ptw_resp_valid_i & ~flush_valid_i;

  assign ptw_req_vpn_o   = wlk_vpn_q;
  assign ptw_req_asid_o  = wlk_asid_q;
  assign ptw_req_store_o = wlk_store_q;
  assign ptw_req_fetch_o = wlk_fetch_q;

  // Victim: lowest empty entry, else the round-robin pointer
  always_comb begin
    have_empty = 1'b0;
    victim     = ptr_q;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!nempty_q[i]) begin
        have_empty = 1'b1;
        victim     = IDX_W'(i);
      end
    end
  end

  // Flush selection by ASID and/or covering VPN; global pages survive ASID flushes
  always_comb begin
    flush_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      case ({flush_asid_en_i, flush_vpn_en_i})
        2'b00:   flush_sel[i] = 1'b1;
        2'b10:   flush_sel[i] = (asid_q[i] == flush_asid_i) & ~g_q[i];
        2'b01:   flush_sel[i] = (((vpn_q[i] ^ flush_vpn_i) & vpn_hi_mask(level_q[i])) == '0);
        default: flush_sel[i] = (asid_q[i] == flush_asid_i) & ~g_q[i] &
                                (((vpn_q[i] ^ flush_vpn_i) & vpn_hi_mask(level_q[i])) == '0);
      endcase
    end
  end

  // Valid bits: fill, then hit-clear, then flush has the last word
  always_comb begin
    nempty_d = nempty_q;
    if (fill_en) nempty_d[fill_idx_q] = 1'b1;
    if (clr_en) nempty_d[hit_idx] = 1'b0;
    if (flush_valid_i) nempty_d = nempty_d & ~flush_sel;
  end

  // Walker next state and handshake outputs
  always_comb begin
    state_d         = state_q;
    ready_o         = 1'b0;
    ptw_req_valid_o = 1'b0;
    pmu_access_o    = 1'b0;
    pmu_miss_o      = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o      = 1'b1;
        pmu_access_o = lookup;
        pmu_miss_o   = accept_miss;
        if (accept_miss) state_d = SEND;
      end
      SEND: begin
        ptw_req_valid_o = 1'b1;
        if (ptw_req_ready_i) state_d = flush_valid_i ? DISCARD : WAIT;
        else if (flush_valid_i) state_d = IDLE;
      end
      WAIT: begin
        if (ptw_resp_valid_i) state_d = IDLE;
        else if (flush_valid_i) state_d = DISCARD;
      end
      DISCARD: if (ptw_resp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Walker state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Latch the missing request and its victim slot when the miss is accepted
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wlk_vpn_q   <= '0;
      wlk_asid_q  <= '0;
      wlk_store_q <= 1'b0;
      wlk_fetch_q <= 1'b0;
      fill_idx_q  <= '0;
      ptr_q       <= '0;
    end else if (accept_miss) begin
      wlk_vpn_q   <= req_vpn_i;
      wlk_asid_q  <= req_asid_i;
      wlk_store_q <= req_store_i;
      wlk_fetch_q <= req_fetch_i;
      fill_idx_q  <= victim;
      if (!have_empty) ptr_q <= ptr_q + 1'b1;
    end
  end

  // Entry array update; permissions are pre-split by privilege at fill
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      nempty_q <= '0;
      g_q      <= '0;
      d_q      <= '0;
      fault_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        vpn_q[i]   <= '0;
        asid_q[i]  <= '0;
        ppn_q[i]   <= '0;
        level_q[i] <= '0;
        perm_q[i]  <= '0;
      end
    end else begin
      nempty_q <= nempty_d;
      if (fill_en) begin
        vpn_q[fill_idx_q]   <= wlk_vpn_q;
        asid_q[fill_idx_q]  <= wlk_asid_q;
        ppn_q[fill_idx_q]   <= ptw_resp_ppn_i;
        level_q[fill_idx_q] <= ptw_resp_level_i;
        g_q[fill_idx_q]     <= ptw_resp_perm_i[6];
        d_q[fill_idx_q]     <= ptw_resp_perm_i[5];
        fault_q[fill_idx_q] <= ptw_resp_error_i;
        perm_q[fill_idx_q]  <= {ptw_resp_perm_i[1] &  ptw_resp_perm_i[4] & ptw_resp_perm_i[0],
                                ptw_resp_perm_i[2] &  ptw_resp_perm_i[4] & ptw_resp_perm_i[0],
                                ptw_resp_perm_i[3] &  ptw_resp_perm_i[4] & ptw_resp_perm_i[0],
                                ptw_resp_perm_i[1] & ~ptw_resp_perm_i[4] & ptw_resp_perm_i[0],
                                ptw_resp_perm_i[2] & ~ptw_resp_perm_i[4] & ptw_resp_perm_i[0],
                                ptw_resp_perm_i[3] & ~ptw_resp_perm_i[4] & ptw_resp_perm_i[0]};
      end
    end
  end
endmodule

// File: tb/tb_tlb_sfence_assoc.sv
// tb/tb_tlb_sfence_assoc.sv - scoreboard bench for tlb_sfence_assoc against a page-table-entry level model
module tb_tlb_sfence_assoc;
  localparam int E = 16;

  logic clk_i = 1'b0, rstn_i = 1'b0;
  logic vm_enable_i = 0, req_valid_i = 0, req_store_i = 0, req_fetch_i = 0, req_priv_s_i = 0;
  logic sum_i = 0, mxr_i = 0, ptw_req_ready_i = 0, ptw_resp_valid_i = 0, ptw_resp_error_i = 0;
  logic flush_valid_i = 0, flush_asid_en_i = 0, flush_vpn_en_i = 0;
  logic [26:0] req_vpn_i = '0, flush_vpn_i = '0;
  logic [15:0] req_asid_i = '0, flush_asid_i = '0;
  logic [43:0] ptw_resp_ppn_i = '0;
  logic [1:0]  ptw_resp_level_i = '0;
  logic [6:0]  ptw_resp_perm_i = '0;
  logic ready_o, resp_miss_o, resp_xcpt_ld_o, resp_xcpt_st_o, resp_xcpt_if_o;
  logic ptw_req_valid_o, ptw_req_store_o, ptw_req_fetch_o, pmu_access_o, pmu_miss_o;
  logic [43:0] resp_ppn_o;
  logic [26:0] ptw_req_vpn_o;
  logic [15:0] ptw_req_asid_o;

  always #5 clk_i = ~clk_i;

  tlb_sfence_assoc dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .vm_enable_i(vm_enable_i), .req_valid_i(req_valid_i),
    .req_vpn_i(req_vpn_i), .req_asid_i(req_asid_i), .req_store_i(req_store_i), .req_fetch_i(req_fetch_i),
    .req_priv_s_i(req_priv_s_i), .sum_i(sum_i), .mxr_i(mxr_i), .ready_o(ready_o),
    .resp_miss_o(resp_miss_o), .resp_ppn_o(resp_ppn_o), .resp_xcpt_ld_o(resp_xcpt_ld_o),
    .resp_xcpt_st_o(resp_xcpt_st_o), .resp_xcpt_if_o(resp_xcpt_if_o), .ptw_req_valid_o(ptw_req_valid_o),
    .ptw_req_ready_i(ptw_req_ready_i), .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_req_asid_o(ptw_req_asid_o),
    .ptw_req_store_o(ptw_req_store_o), .ptw_req_fetch_o(ptw_req_fetch_o), .ptw_resp_valid_i(ptw_resp_valid_i),
    .ptw_resp_ppn_i(ptw_resp_ppn_i), .ptw_resp_level_i(ptw_resp_level_i), .ptw_resp_perm_i(ptw_resp_perm_i),
    .ptw_resp_error_i(ptw_resp_error_i), .flush_valid_i(flush_valid_i), .flush_asid_en_i(flush_asid_en_i),
    .flush_asid_i(flush_asid_i), .flush_vpn_en_i(flush_vpn_en_i), .flush_vpn_i(flush_vpn_i),
    .pmu_access_o(pmu_access_o), .pmu_miss_o(pmu_miss_o)
  );

  typedef struct packed {logic miss; logic [43:0] ppn; logic ld, st, fe, acc, pm;} lk_t;
  typedef struct packed {logic [26:0] vpn; logic [15:0] asid; logic st, fe;} pw_t;
  lk_t lk_q[$];
  pw_t pw_q[$];

  int checks = 0, errors = 0;

  // Reference model: raw PTE bits per slot
  bit          m_v[E];
  logic [26:0] m_vpn[E];
  logic [15:0] m_asid[E];
  logic [43:0] m_ppn[E];
  int          m_lvl[E];
  logic [6:0]  m_perm[E];
  bit          m_fault[E];
  int          m_ptr = 0;
  int          p_idx;
  logic [26:0] p_vpn;
  logic [15:0] p_asid;
  logic [26:0] pool[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit covers(input logic [26:0] a, input logic [26:0] b, input int lvl);
    return (a >> (9 * lvl)) == (b >> (9 * lvl));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < E; i++) m_v[i] = 0;
    m_ptr = 0;
  endtask

  task automatic m_flush();
    bit am, vmt, g, sel;
    for (int i = 0; i < E; i++) begin
      am  = (m_asid[i] == flush_asid_i);
      vmt = covers(m_vpn[i], flush_vpn_i, m_lvl[i]);
      g   = m_perm[i][6];
      case ({flush_asid_en_i, flush_vpn_en_i})
        2'b00:   sel = 1;
        2'b10:   sel = am && !g;
        2'b01:   sel = vmt;
        default: sel = am && vmt && !g;
      endcase
      if (sel) m_v[i] = 0;
    end
  endtask

  task automatic set_flush(input bit ae, input logic [15:0] a, input bit ve, input logic [26:0] v);
    flush_asid_en_i = ae; flush_asid_i = a; flush_vpn_en_i = ve; flush_vpn_i = v;
  endtask

  task automatic set_rand_flush();
    set_flush(1'($urandom), 16'($urandom_range(1, 3)), 1'($urandom),
              pool[$urandom_range(0, 7)] ^ 27'($urandom_range(0, 3)));
  endtask

  task automatic do_flush(input bit ae, input logic [15:0] a, input bit ve, input logic [26:0] v);
    set_flush(ae, a, ve, v);
    flush_valid_i = 1; tick(); flush_valid_i = 0;
    m_flush();
  endtask

  // acc: 0 load, 1 store, 2 fetch
  task automatic lookup(input logic [26:0] vpn, input logic [15:0] asid, input int acc,
                        input bit ps, input bit su, input bit mx, input bit vm, output bit walk);
    lk_t e; int idx, s; bit h, rd, wr, ex, u, v, dirty;
    logic [6:0] p;
    idx = -1; dirty = 0;
    for (int i = 0; i < E; i++)
      if (idx < 0 && m_v[i] && (m_perm[i][6] || m_asid[i] == asid) && covers(m_vpn[i], vpn, m_lvl[i])) idx = i;
    h = (idx >= 0);
    e = '0;
    if (!vm) e.ppn = 44'(vpn);
    else begin
      e.acc = 1;
      if (h) begin
        p = m_perm[idx]; v = p[0]; u = p[4];
        rd = v & p[1] & (ps ? (!u || su) : u);
        if (mx) rd = rd | (v & p[3] & (ps ? !u : u));
        wr = v & p[2] & (ps ? (!u || su) : u);
        ex = v & p[3] & (ps ? !u : u);
        dirty = (acc == 1) && !m_fault[idx] && wr && !p[5];
        s = 9 * m_lvl[idx];
        e.ppn = ((m_ppn[idx] >> s) << s) | (44'(vpn) & ((44'd1 << s) - 44'd1));
        e.ld = (acc == 0) && (m_fault[idx] || !rd);
        e.st = (acc == 1) && (m_fault[idx] || !wr);
        e.fe = (acc == 2) && (m_fault[idx] || !ex);
      end
      e.miss = !h || dirty;
      e.pm   = e.miss;
    end
    lk_q.push_back(e);
    req_vpn_i = vpn; req_asid_i = asid; req_store_i = (acc == 1); req_fetch_i = (acc == 2);
    req_priv_s_i = ps; sum_i = su; mxr_i = mx; vm_enable_i = vm; req_valid_i = 1;
    tick();
    req_valid_i = 0;
    walk = vm && e.miss;
    if (walk) begin
      p_idx = -1;
      for (int i = 0; i < E; i++) if (p_idx < 0 && !m_v[i]) p_idx = i;
      if (p_idx < 0) begin p_idx = m_ptr; m_ptr = (m_ptr + 1) % E; end
      p_vpn = vpn; p_asid = asid;
      pw_q.push_back({vpn, asid, acc == 1, acc == 2});
    end
    if (vm && h && (m_fault[idx] || dirty)) m_v[idx] = 0;
  endtask

  // mode: 0 fill, 1 flush in WAIT, 2 withdraw in SEND, 3 flush with ready, 4 flush with response
  task automatic walk(input int mode, input logic [43:0] ppn, input int lvl, input logic [6:0] perm, input bit err);
    int n = 0;
    while (!ptw_req_valid_o && n < 10) begin tick(); n++; end
    chk("walk_start", ptw_req_valid_o, 1);
    if (!ptw_req_valid_o) return;
    if (mode == 2) begin
      set_rand_flush(); flush_valid_i = 1; tick(); flush_valid_i = 0; m_flush();
      chk("withdraw_ready", ready_o, 1);
      chk("withdraw_valid", ptw_req_valid_o, 0);
      return;
    end
    repeat ($urandom_range(0, 2)) tick();
    ptw_req_ready_i = 1;
    if (mode == 3) begin set_rand_flush(); flush_valid_i = 1; end
    tick();
    ptw_req_ready_i = 0;
    if (mode == 3) begin flush_valid_i = 0; m_flush(); end
    chk("walk_busy", ready_o, 0);
    repeat ($urandom_range(0, 2)) tick();
    if (mode == 1) begin set_rand_flush(); flush_valid_i = 1; tick(); flush_valid_i = 0; m_flush(); end
    ptw_resp_valid_i = 1; ptw_resp_ppn_i = ppn; ptw_resp_level_i = 2'(lvl);
    ptw_resp_perm_i = perm; ptw_resp_error_i = err;
    if (mode == 4) begin set_rand_flush(); flush_valid_i = 1; end
    tick();
    ptw_resp_valid_i = 0;
    if (mode == 4) begin flush_valid_i = 0; m_flush(); end
    if (mode == 0) begin
      m_v[p_idx] = 1; m_vpn[p_idx] = p_vpn; m_asid[p_idx] = p_asid; m_ppn[p_idx] = ppn;
      m_lvl[p_idx] = lvl; m_perm[p_idx] = perm; m_fault[p_idx] = err;
    end
    chk("walk_done_ready", ready_o, 1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a lookup response or a new walk request
  bit ptw_prev = 0;
  always @(negedge clk_i) begin
    lk_t e; pw_t p;
    if (!rstn_i) ptw_prev = 0;
    else begin
      if (req_valid_i && ready_o) begin
        if (lk_q.size() == 0) chk("lk_unexpected", 1, 0);
        else begin
          e = lk_q.pop_front();
          chk("miss", resp_miss_o, e.miss);
          if (!e.miss) chk("ppn", resp_ppn_o, e.ppn);
          chk("xcpt_ld", resp_xcpt_ld_o, e.ld);
          chk("xcpt_st", resp_xcpt_st_o, e.st);
          chk("xcpt_if", resp_xcpt_if_o, e.fe);
          chk("pmu_access", pmu_access_o, e.acc);
          chk("pmu_miss", pmu_miss_o, e.pm);
        end
      end
      if (ptw_req_valid_o && !ptw_prev) begin
        if (pw_q.size() == 0) chk("ptw_unexpected", 1, 0);
        else begin
          p = pw_q.pop_front();
          chk("ptw_vpn", ptw_req_vpn_o, p.vpn);
          chk("ptw_asid", ptw_req_asid_o, p.asid);
          chk("ptw_store", ptw_req_store_o, p.st);
          chk("ptw_fetch", ptw_req_fetch_o, p.fe);
        end
      end
      ptw_prev = ptw_req_valid_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit w;
    int mode, lvl, acc;
    logic [63:0] r64;
    logic [6:0] perm;
    bit err;
    for (int i = 0; i < 8; i++) pool[i] = 27'($urandom);
    m_reset();
    repeat (3) tick();
    chk("rst_ready", ready_o, 1);
    chk("rst_ptw_valid", ptw_req_valid_o, 0);
    rstn_i = 1;
    tick();
    chk("idle_ready", ready_o, 1);
    chk("idle_pmu", {pmu_access_o, pmu_miss_o}, 0);

    // Superpage fill and offset pass-through
    lookup(27'h12345, 16'd1, 0, 1, 0, 0, 1, w);
    walk(0, 44'h80200, 1, 7'h2F, 0);
    lookup(27'h123FF, 16'd1, 0, 1, 0, 0, 1, w);
    // Bare mode
    lookup(27'h7ABCD, 16'd9, 1, 0, 0, 0, 0, w);

    // Global entry survives an ASID flush, not a full flush
    lookup(27'h00777, 16'd1, 0, 1, 0, 0, 1, w);
    walk(0, 44'h55555, 0, 7'h6F, 0);
    lookup(27'h00777, 16'd2, 0, 1, 0, 0, 1, w);
    do_flush(1, 16'd1, 0, '0);
    lookup(27'h00777, 16'd2, 0, 1, 0, 0, 1, w);
    do_flush(0, '0, 0, '0);
    lookup(27'h00777, 16'd2, 0, 1, 0, 0, 1, w);
    if (w) walk(0, 44'h11111, 0, 7'h2F, 0);

    // Dirty upgrade on a clean writable page
    lookup(27'h00ABC, 16'd1, 0, 1, 0, 0, 1, w);
    if (w) walk(0, 44'h22222, 0, 7'h0F, 0);
    lookup(27'h00ABC, 16'd1, 1, 1, 0, 0, 1, w);
    if (w) walk(0, 44'h22222, 0, 7'h2F, 0);
    lookup(27'h00ABC, 16'd1, 1, 1, 0, 0, 1, w);

    // Flush during WAIT drops the fill
    lookup(27'h0AAAA, 16'd3, 0, 0, 0, 0, 1, w);
    if (w) walk(1, 44'h33333, 0, 7'h3F, 0);
    lookup(27'h0AAAA, 16'd3, 0, 0, 0, 0, 1, w);
    if (w) walk(0, 44'h33333, 0, 7'h3F, 0);

    // Reset while a walk is outstanding; late response ignored
    lookup(27'h05555, 16'd2, 0, 1, 0, 0, 1, w);
    if (w) begin
      ptw_req_ready_i = 1; tick(); ptw_req_ready_i = 0;
    end
    rstn_i = 0; m_reset();
    tick();
    chk("reset_mid_ready", ready_o, 1);
    chk("reset_mid_ptw", ptw_req_valid_o, 0);
    rstn_i = 1;
    tick();
    ptw_resp_valid_i = 1; ptw_resp_perm_i = 7'h2F; ptw_resp_ppn_i = 44'h44444; tick(); ptw_resp_valid_i = 0;
    lookup(27'h05555, 16'd2, 0, 1, 0, 0, 1, w);
    if (w) walk(2, 44'h0, 0, 7'h0, 0);

    // Fill all slots, then round-robin eviction from slot 0
    do_flush(0, '0, 0, '0);
    for (int i = 0; i < 17; i++) begin
      lookup(27'h40000 + 27'(i), 16'd5, 0, 1, 0, 0, 1, w);
      if (w) walk(0, 44'h90000 + 44'(i), 0, 7'h2F, 0);
    end
    for (int i = 0; i < 3; i++) begin
      lookup(27'h40000 + 27'(i), 16'd5, 0, 1, 0, 0, 1, w);
      if (w) walk(0, 44'hA0000 + 44'(i), 0, 7'h2F, 0);
    end

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        set_rand_flush(); flush_valid_i = 1; tick(); flush_valid_i = 0; m_flush();
      end else begin
        acc = $urandom_range(0, 2);
        lookup(pool[$urandom_range(0, 7)] ^ 27'($urandom_range(0, 3)), 16'($urandom_range(1, 3)), acc,
               1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 9) != 0, w);
        if (w) begin
          mode = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 4);
          err  = ($urandom_range(0, 9) == 0);
          perm = err ? 7'h00 : (7'($urandom) | 7'h01);
          lvl  = $urandom_range(0, 2);
          r64  = {$urandom, $urandom};
          walk(mode, r64[43:0], lvl, perm, err);
        end
      end
    end

    repeat (3) tick();
    chk("lk_q_drained", lk_q.size(), 0);
    chk("pw_q_drained", pw_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
